// File: rtl/display_scan_controller.sv
// Purpose : sequences the calculator display datapath (digit scan, view select, result hold, leading-zero blanking).
// Latency : every output is registered; a calc_done/new_input pulse shows on the outputs one cycle later.
// Backpress: none; pulse inputs are acted on in the cycle they arrive and the scan free-runs.
//
// Ports:
//   i_clk, i_reset_n           clock, synchronous active-low reset
//   i_calc_done                one-cycle pulse, i_alu_output/i_alu_sign valid this cycle
//   i_new_input                one-cycle pulse, user changed operand/operation
//   i_alu_output[11:0]         BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones
//   i_alu_sign, i_input_sign   result sign / user operand sign, 1 = negative
//   o_disp_alu_value[11:0]     latched BCD result for the datapath
//   o_disp_alu_sign            latched result sign for the datapath
//   o_four_to_one_sel[1:0]     digit slot: 00 ones, 01 tens, 10 hundreds, 11 sign
//   o_two_to_one_sel           0 = user operand view, 1 = ALU result view
//   o_digit_blank              1 = current slot dark
//   o_scan_tick                one-cycle pulse at each digit advance
module display_scan_controller #(
   parameter int REFRESH_DIV = 100000,
   parameter int HOLD_TICKS  = 3000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_calc_done,
   input  logic        i_new_input,
   input  logic [11:0] i_alu_output,
   input  logic        i_alu_sign,
   input  logic        i_input_sign,
   output logic [11:0] o_disp_alu_value,
   output logic        o_disp_alu_sign,
   output logic [1:0]  o_four_to_one_sel,
   output logic        o_two_to_one_sel,
   output logic        o_digit_blank,
   output logic        o_scan_tick
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'((HOLD_TICKS > 0) ? (HOLD_TICKS - 1) : 0);

   typedef enum logic {
      ST_INPUT  = 1'b0,
      ST_RESULT = 1'b1
   } state_t;

   state_t         r_state;
   logic [PW-1:0]  r_presc;
   logic [1:0]     r_sel;
   logic           r_tick;
   logic [HW-1:0]  r_hold;
   logic [11:0]    r_value;
   logic           r_sign;
   logic           r_blank;

   state_t         w_state_nxt;
   logic           w_wrap;
   logic [PW-1:0]  w_presc_nxt;
   logic [1:0]     w_sel_nxt;
   logic [HW-1:0]  w_hold_nxt;
   logic [11:0]    w_value_nxt;
   logic           w_sign_nxt;
   logic           w_blank_nxt;

   // Digit scan: free-running, never disturbed by the view FSM.
   always_comb begin
      w_wrap      = (r_presc == PRESC_LAST);
      w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
      w_sel_nxt   = w_wrap ? r_sel + 2'd1 : r_sel;
   end

   // View FSM. The hold counter advances on the registered tick, so a
   // timeout becomes visible the cycle after the tick that caused it.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_value_nxt = r_value;
      w_sign_nxt  = r_sign;
      if (i_calc_done) begin
         // Fresh result always wins, in any state, and restarts the hold.
         w_state_nxt = ST_RESULT;
         w_hold_nxt  = '0;
         w_value_nxt = i_alu_output;
         w_sign_nxt  = i_alu_sign;
      end else begin
         case (r_state)
            ST_INPUT: begin
               w_state_nxt = ST_INPUT;
            end
            ST_RESULT: begin
               if (i_new_input) begin
                  w_state_nxt = ST_INPUT;
               end else if (r_tick && (HOLD_TICKS != 0)) begin
                  if (r_hold == HOLD_LAST) begin
                     w_state_nxt = ST_INPUT;
                  end else begin
                     w_hold_nxt = r_hold + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_INPUT;
            end
         endcase
      end
   end

   // Blanking is decided from the values that will be on the outputs next
   // cycle, so the registered blank lines up with the registered slot.
   always_comb begin
      w_blank_nxt = 1'b0;
      if (w_state_nxt == ST_RESULT) begin
         case (w_sel_nxt)
            2'b00:   w_blank_nxt = 1'b0;
            2'b01:   w_blank_nxt = (w_value_nxt[11:8] == 4'd0) && (w_value_nxt[7:4] == 4'd0);
            2'b10:   w_blank_nxt = (w_value_nxt[11:8] == 4'd0);
            default: w_blank_nxt = ~w_sign_nxt;
         endcase
      end else begin
         // Operand view shows two digits plus sign; hundreds is never used.
         case (w_sel_nxt)
            2'b00:   w_blank_nxt = 1'b0;
            2'b01:   w_blank_nxt = 1'b0;
            2'b10:   w_blank_nxt = 1'b1;
            default: w_blank_nxt = ~i_input_sign;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= ST_INPUT;
         r_presc <= '0;
         r_sel   <= 2'b00;
         r_tick  <= 1'b0;
         r_hold  <= '0;
         r_value <= 12'h000;
         r_sign  <= 1'b0;
         r_blank <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_sel   <= w_sel_nxt;
         r_tick  <= w_wrap;
         r_hold  <= w_hold_nxt;
         r_value <= w_value_nxt;
         r_sign  <= w_sign_nxt;
         r_blank <= w_blank_nxt;
      end
   end

   assign o_disp_alu_value  = r_value;
   assign o_disp_alu_sign   = r_sign;
   assign o_four_to_one_sel = r_sel;
   assign o_two_to_one_sel  = (r_state == ST_RESULT);
   assign o_digit_blank     = r_blank;
   assign o_scan_tick       = r_tick;

endmodule

// File: tb/tb_display_scan_controller.sv
// Purpose : self-checking bench for display_scan_controller (two instances: timed hold and hold-until-input).
// Latency : reference model advances on each rising edge, outputs compared on the falling edge.
// Backpress: none; stimulus is pulse based.
module tb_display_scan_controller;

   localparam int DIV   = 4;
   localparam int HOLD0 = 3;
   localparam int HOLD1 = 0;

   logic        clk;
   logic        reset_n;
   logic        calc_done;
   logic        new_input;
   logic [11:0] alu_output;
   logic        alu_sign;
   logic        input_sign;

   logic [11:0] dval [2];
   logic        dsgn [2];
   logic [1:0]  sel  [2];
   logic        view [2];
   logic        blnk [2];
   logic        tick [2];

   int total = 0;
   int bad   = 0;

   // Reference model: edges since reset release, latched result, per-instance view and ticks held.
   int          n;
   bit          m_view  [2];
   int          m_ticks [2];
   logic [11:0] m_val;
   bit          m_sign;
   int          exp_sel;
   bit          exp_tick;
   bit          exp_blank [2];

   display_scan_controller #(.REFRESH_DIV(DIV), .HOLD_TICKS(HOLD0)) u_dut0 (
      .i_clk(clk), .i_reset_n(reset_n), .i_calc_done(calc_done), .i_new_input(new_input),
      .i_alu_output(alu_output), .i_alu_sign(alu_sign), .i_input_sign(input_sign),
      .o_disp_alu_value(dval[0]), .o_disp_alu_sign(dsgn[0]), .o_four_to_one_sel(sel[0]),
      .o_two_to_one_sel(view[0]), .o_digit_blank(blnk[0]), .o_scan_tick(tick[0])
   );

   display_scan_controller #(.REFRESH_DIV(DIV), .HOLD_TICKS(HOLD1)) u_dut1 (
      .i_clk(clk), .i_reset_n(reset_n), .i_calc_done(calc_done), .i_new_input(new_input),
      .i_alu_output(alu_output), .i_alu_sign(alu_sign), .i_input_sign(input_sign),
      .o_disp_alu_value(dval[1]), .o_disp_alu_sign(dsgn[1]), .o_four_to_one_sel(sel[1]),
      .o_two_to_one_sel(view[1]), .o_digit_blank(blnk[1]), .o_scan_tick(tick[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // A slot is dark when it would show a leading zero (ones is always lit),
   // or it is the sign slot of a positive number. Operand view never lights hundreds.
   function automatic bit blank_of(bit v, int s, logic [11:0] val, bit sg, bit isg);
      if (s == 3) return v ? !sg : !isg;
      if (!v) return (s == 2);
      if (s == 0) return 1'b0;
      for (int p = s; p <= 2; p++) begin
         if (val[p*4 +: 4] != 4'd0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge();
      bit prev_tick;
      int h;
      prev_tick = (n > 0) && (n % DIV == 0);
      if (!reset_n) begin
         n = 0;
         m_val = 12'h000;
         m_sign = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_view[k] = 1'b0;
            m_ticks[k] = 0;
         end
      end else begin
         n++;
         if (calc_done) begin
            m_val = alu_output;
            m_sign = alu_sign;
            for (int k = 0; k < 2; k++) begin
               m_view[k] = 1'b1;
               m_ticks[k] = 0;
            end
         end else begin
            for (int k = 0; k < 2; k++) begin
               h = (k == 0) ? HOLD0 : HOLD1;
               if (m_view[k]) begin
                  if (new_input) begin
                     m_view[k] = 1'b0;
                  end else if (prev_tick) begin
                     m_ticks[k]++;
                     if (h != 0 && m_ticks[k] == h) m_view[k] = 1'b0;
                  end
               end
            end
         end
      end
      exp_sel  = (n / DIV) % 4;
      exp_tick = (n > 0) && (n % DIV == 0);
      for (int k = 0; k < 2; k++)
         exp_blank[k] = blank_of(m_view[k], exp_sel, m_val, m_sign, input_sign);
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("sel%0d", k),   32'(sel[k]),  32'(exp_sel));
         chk($sformatf("tick%0d", k),  32'(tick[k]), 32'(exp_tick));
         chk($sformatf("view%0d", k),  32'(view[k]), 32'(m_view[k]));
         chk($sformatf("blank%0d", k), 32'(blnk[k]), 32'(exp_blank[k]));
         chk($sformatf("value%0d", k), 32'(dval[k]), 32'(m_val));
         chk($sformatf("sign%0d", k),  32'(dsgn[k]), 32'(m_sign));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      calc_done = 1'b0;
      new_input = 1'b0;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) cycle();
   endtask

   task automatic pulse_calc(input logic [11:0] v, input logic s);
      calc_done  = 1'b1;
      alu_output = v;
      alu_sign   = s;
      cycle();
   endtask

   function automatic logic [11:0] rand_bcd();
      logic [11:0] r;
      r[11:8] = 4'($urandom_range(0, 9));
      r[7:4]  = 4'($urandom_range(0, 9));
      r[3:0]  = 4'($urandom_range(0, 9));
      return r;
   endfunction

   initial begin
      n = 0;
      m_val = 12'h000;
      m_sign = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_view[k] = 1'b0;
         m_ticks[k] = 0;
      end
      reset_n    = 1'b0;
      calc_done  = 1'b0;
      new_input  = 1'b0;
      alu_output = 12'h000;
      alu_sign   = 1'b0;
      input_sign = 1'b0;

      // Reset and free-running scan.
      run(3);
      chk("rst_sel",   32'(sel[0]),  32'd0);
      chk("rst_view",  32'(view[0]), 32'd0);
      chk("rst_blank", 32'(blnk[0]), 32'd0);
      chk("rst_tick",  32'(tick[0]), 32'd0);
      chk("rst_value", 32'(dval[0]), 32'd0);
      reset_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         chk("scan_tick_pos", 32'(tick[0]), 32'(i % 4 == 0));
         chk("scan_sel_seq",  32'(sel[0]),  32'((i / 4) % 4));
      end

      // Latch and blank, then timeout on the timed instance only.
      pulse_calc(12'h042, 1'b1);
      chk("latch_view",  32'(view[0]), 32'd1);
      chk("latch_value", 32'(dval[0]), 32'h042);
      alu_output = 12'h999;
      run(8);
      chk("latch_stable", 32'(dval[0]), 32'h042);
      run(200);
      chk("hold0_timeout", 32'(view[0]), 32'd0);
      chk("hold_forever",  32'(view[1]), 32'd1);

      // Re-latch restarts the hold.
      pulse_calc(12'h007, 1'b0);
      run(8);
      pulse_calc(12'h100, 1'b0);
      run(16);

      // calc_done beats new_input.
      new_input = 1'b1;
      pulse_calc(12'h305, 1'b1);
      chk("prio_view0", 32'(view[0]), 32'd1);
      chk("prio_view1", 32'(view[1]), 32'd1);

      // new_input exit.
      run(2);
      new_input = 1'b1;
      cycle();
      chk("exit_view0", 32'(view[0]), 32'd0);
      chk("exit_view1", 32'(view[1]), 32'd0);
      run(6);

      // Reset while mid-hold.
      pulse_calc(12'h555, 1'b0);
      for (int i = 0; i < 64 && m_ticks[0] != 1; i++) cycle();
      chk("midhold_view", 32'(view[0]), 32'd1);
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      chk("midrst_view",  32'(view[0]), 32'd0);
      chk("midrst_value", 32'(dval[0]), 32'd0);
      chk("midrst_sel",   32'(sel[0]),  32'd0);
      run(DIV);
      chk("midrst_tick",  32'(tick[0]), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         reset_n    = ($urandom_range(0, 499) != 0);
         calc_done  = ($urandom_range(0, 39) == 0);
         new_input  = ($urandom_range(0, 29) == 0);
         alu_output = rand_bcd();
         if ($urandom_range(0, 3) == 0) alu_output[11:4] = 8'h00;
         alu_sign   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) input_sign = ~input_sign;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Sequences the calculator display datapath (display_data_output_circuit).
- Time-multiplexes the four digit positions by driving four_to_one_sel at a fixed refresh rate.
- Drives two_to_one_sel to choose between the live user operand and a latched ALU result.
- Holds the latched result on screen for a programmable time, blanks leading zeros and a positive sign, and returns to input view on timeout or new user entry.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Minimum 2.
- HOLD_TICKS, 3000: scan ticks the result stays displayed. 0 = hold until new_input.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- calc_done  in  1  one-cycle pulse; ALU_output/alu_sign valid this cycle.
- new_input  in  1  one-cycle pulse; user changed operand/operation.
- ALU_output  in  12  BCD result from ALU: [11:8] hundreds, [7:4] tens, [3:0] ones.
- alu_sign  in  1  ALU result sign, 1 = negative.
- input_sign  in  1  user operand sign, 1 = negative.
- disp_alu_value  out  12  latched BCD result fed to datapath ALU_output input.
- disp_alu_sign  out  1  latched sign fed to datapath alu_sign input.
- four_to_one_sel  out  2  digit slot: 00 ones, 01 tens, 10 hundreds, 11 sign.
- two_to_one_sel  out  1  0 = user operand view, 1 = ALU result view.
- digit_blank  out  1  1 = current slot dark; datapath gates AN with it.
- scan_tick  out  1  one-cycle pulse at each digit advance.

Behaviour:
- Clocking and reset:
  - All outputs are registered; all state changes on the rising edge of clk.
  - reset_n=0 at an edge clears everything, overriding any pulse in the same cycle, including mid-hold.
  - Reset values: four_to_one_sel=00, two_to_one_sel=0, digit_blank=0, scan_tick=0, disp_alu_value=0, disp_alu_sign=0, state=INPUT, prescaler=0, hold counter=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, scan_tick=1 for exactly one cycle and four_to_one_sel increments mod 4 (11 -> 00).
  - The first tick after reset occurs REFRESH_DIV cycles after reset deasserts.
- FSM states:
  - INPUT (two_to_one_sel=0):
    - calc_done -> RESULT.
    - new_input has no effect.
  - RESULT (two_to_one_sel=1):
    - calc_done -> stay in RESULT, re-latch, hold counter=0.
    - else new_input -> INPUT.
    - else, when HOLD_TICKS≠0 and hold counter reaches HOLD_TICKS-1 on a scan_tick -> INPUT.
    - Otherwise the hold counter increments on each scan_tick.
- Latching:
  - On calc_done (any state), disp_alu_value<=ALU_output and disp_alu_sign<=alu_sign; the hold counter clears.
  - The change is visible the next cycle, and two_to_one_sel switches to 1 that same cycle.
  - Between calc_done pulses, latched values are stable regardless of ALU_output.
- Simultaneous events:
  - calc_done with new_input: calc_done wins.
  - calc_done on a scan_tick cycle: the latch and hold restart happen and the digit still advances.
  - Timeout tick coinciding with new_input: -> INPUT, no conflict.
  - The FSM and digit scan are independent; a state change never resets the prescaler or four_to_one_sel.
- Blanking (computed from next-state values so it aligns with four_to_one_sel; registered):
  - RESULT view:
    - sel 00 never blanked (0 shows "0").
    - sel 01 blanked iff value[11:8]=0 and value[7:4]=0.
    - sel 10 blanked iff value[11:8]=0.
    - sel 11 blanked iff sign=0.
  - INPUT view:
    - sel 00, 01 never blanked.
    - sel 10 always blanked.
    - sel 11 blanked iff input_sign=0.

Test Plan:
- Reset/scan (REFRESH_DIV=4): hold reset_n=0 three cycles, release. Expect all outputs at reset values. scan_tick on cycles 4, 8, 12, 16; sel sequence 00,01,10,11,00; digit_blank sequence 0,0,1,1 with input_sign=0.
- Latch/blank: calc_done with ALU_output=12'h042, alu_sign=1. Next cycle expect two_to_one_sel=1 and disp_alu_value=12'h042. Over one scan, blanks 0,0,1,0. Changing ALU_output to 12'h999 afterwards leaves disp_alu_value=12'h042.
- Hold timeout (HOLD_TICKS=3): after calc_done, two_to_one_sel stays 1 through two ticks and drops to 0 on the cycle after the third tick. With HOLD_TICKS=0 it stays 1 for 50 ticks.
- Re-latch and priority:
  - calc_done (12'h007) then, after two ticks, calc_done (12'h100): expect the hold to restart (three more ticks to timeout) and blanks 0,0,0,1 for sel 00..11.
  - calc_done and new_input asserted in the same cycle: expect RESULT.
- new_input exit: in RESULT, pulse new_input. Next cycle two_to_one_sel=0 and the sel sequence is uninterrupted.
- Reset mid-hold: in RESULT with the hold counter at 1, assert reset_n=0 for one cycle. Expect INPUT, disp_alu_value=0, sel=00, and the next tick REFRESH_DIV cycles later.
